serial_rx_cfg: RTL and testbench

Parametrised UART receiver for FPGA-side serial links, for example the debug/command port on the video card. Generalises the fixed 8N1 receiver to configurable data width, parity and stop bits. Adds an input synchroniser, false-start rejection, and per-frame parity/framing error flags. Sits between the board RX pin and the command parser; emits one-cycle strobes with the received word and its status.

---
 rtl/serial_rx_cfg_if.sv | 15 +
 rtl/serial_rx_cfg.sv | 187 ++++++++++++++++++
 tb/tb_serial_rx_cfg.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_cfg_if.sv
// serial_rx_cfg_if: serial line plus received-word/status bundle for serial_rx_cfg.
// master = line side / consumer (drives rx), slave = the receiver.
interface serial_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 new_data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 brk;

  modport master (output rx, input data, new_data, parity_err, frame_err, brk);
  modport slave  (input rx, output data, new_data, parity_err, frame_err, brk);
endinterface

// File: rtl/serial_rx_cfg.sv
// serial_rx_cfg: configurable UART receiver (data width, parity, stop bits)
// with a two-flop input synchroniser, false-start rejection and per-frame
// parity/framing flags reported with a one-cycle new_data strobe.
// Optional break detection is compiled in with `define SERIAL_RX_BREAK_EN.
// rst is asserted asynchronously; its release is expected to be synchronous to clk.
module serial_rx_cfg #(
  parameter int CLK_PER_BIT = 50,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_rx_cfg_if.slave bus
);
  localparam int CW = $clog2(CLK_PER_BIT) + 1;
  localparam int IW = 4;
  localparam logic [CW-1:0] HALF      = CW'(CLK_PER_BIT >> 1);
  localparam logic [CW-1:0] LAST      = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  if (CLK_PER_BIT < 4) begin : g_bad_cpb
    $error("serial_rx_cfg: CLK_PER_BIT must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("serial_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("serial_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("serial_rx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_WAIT  = 3'd5
  } state_t;

  state_t               state, state_nx;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [CW-1:0]        ctr;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 par_fail;
  logic                 bit_tick;
  logic                 ctr_run;
  logic                 sample;
  logic                 last_stop;
  logic [DATA_BITS-1:0] data_q;
  logic                 new_q, perr_q, ferr_q;

  // two-flop synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], bus.rx};
  end
  assign rx_s     = sync[1];
  assign bit_tick = (ctr == LAST);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // next-state logic; a stop bit sampled low parks in S_WAIT until the line recovers
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!rx_s) state_nx = S_START;
      S_START: if (ctr == HALF) state_nx = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (bit_tick && bit_idx == LAST_DATA)
                 state_nx = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (bit_tick) state_nx = S_STOP;
      S_STOP:  if (bit_tick && bit_idx == LAST_STOP)
                 state_nx = rx_s ? S_IDLE : S_WAIT;
      S_WAIT:  if (rx_s) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // per-state datapath controls
  always_comb begin
    ctr_run   = 1'b0;
    sample    = 1'b0;
    last_stop = 1'b0;
    case (state)
      S_START: ctr_run = 1'b1;
      S_DATA, S_PAR: begin
        ctr_run = 1'b1;
        sample  = bit_tick;
      end
      S_STOP: begin
        ctr_run   = 1'b1;
        sample    = bit_tick;
        last_stop = bit_tick && (bit_idx == LAST_STOP);
      end
      default: ;
    endcase
  end

  // bit-period counter and bit index; both restart on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr     <= '0;
      bit_idx <= '0;
    end else if (state_nx != state) begin
      ctr     <= '0;
      bit_idx <= '0;
    end else if (sample) begin
      ctr     <= '0;
      bit_idx <= bit_idx + IW'(1);
    end else if (ctr_run) begin
      ctr     <= ctr + CW'(1);
    end
  end

  // shift register (LSB first on the wire), parity bit and stop-bit error accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (state == S_START) ferr_acc <= 1'b0;
      if (sample && state == S_DATA) shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
      if (sample && state == S_PAR)  par_bit <= rx_s;
      if (sample && state == S_STOP && !rx_s) ferr_acc <= 1'b1;
    end
  end

  // odd parity fails when the XOR is 0, even parity when it is 1
  assign par_fail = (PARITY != 0) && ((^shreg ^ par_bit) != (PARITY == 1));

  // result registers: loaded together with the one-cycle strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      new_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      new_q <= last_stop;
      if (last_stop) begin
        data_q <= shreg;
        perr_q <= par_fail;
        ferr_q <= ferr_acc | ~rx_s;
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.new_data   = new_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;

`ifdef SERIAL_RX_BREAK_EN
  logic one_seen, brk_q;

  // remembers whether any sampled bit of the current frame was high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     one_seen <= 1'b0;
    else if (state == S_START)    one_seen <= 1'b0;
    else if (sample && rx_s)      one_seen <= 1'b1;
  end

  // break = every sampled bit low, including the final stop bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           brk_q <= 1'b0;
    else if (last_stop) brk_q <= ~(one_seen | rx_s);
  end

  assign bus.brk = brk_q;
`else
  assign bus.brk = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_cfg.sv
// tb_serial_rx_cfg: two receivers (even parity/1 stop, no parity/2 stops) driven
// with directed and random frames; results checked against a frame-level model.
module tb_serial_rx_cfg;
  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef SERIAL_RX_BREAK_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
    logic          brk;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res_t q0[$];
  res_t q1[$];
  res_t none[$];

  always #5 clk = ~clk;

  serial_rx_cfg_if #(.DATA_BITS(DB)) bus0 ();
  serial_rx_cfg_if #(.DATA_BITS(DB)) bus1 ();

  serial_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  serial_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // collect every strobe; a strobe longer than one cycle shows up as extra entries
  always @(negedge clk) begin
    if (bus0.new_data === 1'b1) q0.push_back({bus0.data, bus0.parity_err, bus0.frame_err, bus0.brk});
    if (bus1.new_data === 1'b1) q1.push_back({bus1.data, bus1.parity_err, bus1.frame_err, bus1.brk});
  end

  function automatic int par_of(input int w);  return (w == 0) ? 2 : 0; endfunction
  function automatic int stops_of(input int w); return (w == 0) ? 1 : 2; endfunction
  function automatic int qsize(input int w);   return (w == 0) ? q0.size() : q1.size(); endfunction
  function automatic res_t pop(input int w);
    if (w == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // wire levels of one frame, one entry per bit period
  function automatic void build(input logic [DB-1:0] d, input int w, input bit bad_par,
                                input bit st0, input bit st1, output bit lv[$]);
    lv = {};
    lv.push_back(1'b0);
    for (int k = 0; k < DB; k++) lv.push_back(d[k]);
    if (par_of(w) == 1) lv.push_back(~(^d) ^ bad_par);
    if (par_of(w) == 2) lv.push_back((^d) ^ bad_par);
    lv.push_back(st0);
    if (stops_of(w) == 2) lv.push_back(st1);
  endfunction

  // reference: interpret the bit periods of a frame by position
  function automatic res_t model(input bit lv[$], input int w);
    res_t r;
    int   idx, ones;
    bit   any1;
    r    = '0;
    any1 = 1'b0;
    for (int k = 0; k < DB; k++) begin
      r.data[k] = lv[1 + k];
      any1 |= lv[1 + k];
    end
    ones = $countones(r.data);
    idx  = DB + 1;
    if (par_of(w) != 0) begin
      ones += int'(lv[idx]);
      any1 |= lv[idx];
      r.perr = (par_of(w) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      idx++;
    end
    for (int s = 0; s < stops_of(w); s++) begin
      if (!lv[idx + s]) r.ferr = 1'b1;
      any1 |= lv[idx + s];
    end
    r.brk = BRK_EN && !any1;
    return r;
  endfunction

  task automatic set_rx(input int w, input bit v);
    if (w == 0) bus0.rx = v;
    else        bus1.rx = v;
  endtask

  task automatic send(input int w, input bit lv[$]);
    foreach (lv[k]) begin
      set_rx(w, lv[k]);
      repeat (CPB) @(negedge clk);
    end
    set_rx(w, 1'b1);
  endtask

  task automatic expect_frames(input int w, input res_t exps[$], input string tag);
    int   n;
    res_t got;
    n = 0;
    while (qsize(w) < exps.size() && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    repeat (CPB) @(negedge clk);
    checks++;
    assert (qsize(w) == exps.size()) else begin
      errors++;
      $error("FAIL %s strobes: got %0d want %0d", tag, qsize(w), exps.size());
    end
    foreach (exps[k]) begin
      if (qsize(w) > 0) begin
        got = pop(w);
        checks++;
        assert (got === exps[k]) else begin
          errors++;
          $error("FAIL %s frame%0d: got data=%h perr=%b ferr=%b brk=%b want data=%h perr=%b ferr=%b brk=%b",
                 tag, k, got.data, got.perr, got.ferr, got.brk,
                 exps[k].data, exps[k].perr, exps[k].ferr, exps[k].brk);
        end
      end
    end
    if (w == 0) q0 = {};
    else        q1 = {};
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert ({bus0.data, bus0.new_data, bus0.parity_err, bus0.frame_err, bus0.brk} === '0) else begin
      errors++;
      $error("FAIL %s dut0: got %h want 0", tag,
             {bus0.data, bus0.new_data, bus0.parity_err, bus0.frame_err, bus0.brk});
    end
    checks++;
    assert ({bus1.data, bus1.new_data, bus1.parity_err, bus1.frame_err, bus1.brk} === '0) else begin
      errors++;
      $error("FAIL %s dut1: got %h want 0", tag,
             {bus1.data, bus1.new_data, bus1.parity_err, bus1.frame_err, bus1.brk});
    end
  endtask

  initial begin
    bit   lv[$], lv2[$];
    res_t exps[$];
    int   w, gap;
    bit   bp, s0, s1;
    logic [DB-1:0] d;

    bus0.rx = 1'b1;
    bus1.rx = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // 1: clean even-parity frame
    build(8'hA5, 0, 1'b0, 1'b1, 1'b1, lv);
    send(0, lv);
    exps = {model(lv, 0)};
    expect_frames(0, exps, "t1_a5");

    // 2: wrong parity, then a clean frame clears the flag
    build(8'h3C, 0, 1'b1, 1'b1, 1'b1, lv);
    send(0, lv);
    exps = {model(lv, 0)};
    expect_frames(0, exps, "t2_3c_bad_par");
    build(8'h01, 0, 1'b0, 1'b1, 1'b1, lv);
    send(0, lv);
    exps = {model(lv, 0)};
    expect_frames(0, exps, "t2_01");

    // 3: second stop bit low, line held low 3 bit periods, no retrigger
    build(8'h55, 1, 1'b0, 1'b1, 1'b0, lv);
    exps = {model(lv, 1)};
    for (int k = 0; k < 3; k++) lv.push_back(1'b0);
    send(1, lv);
    expect_frames(1, exps, "t3_55_ferr");
    build(8'h80, 1, 1'b0, 1'b1, 1'b1, lv);
    send(1, lv);
    exps = {model(lv, 1)};
    expect_frames(1, exps, "t3_80");

    // 4: 6-cycle glitch is rejected, next frame is clean
    bus0.rx = 1'b0;
    repeat (6) @(negedge clk);
    bus0.rx = 1'b1;
    expect_frames(0, none, "t4_glitch");
    build(8'hFF, 0, 1'b0, 1'b1, 1'b1, lv);
    send(0, lv);
    exps = {model(lv, 0)};
    expect_frames(0, exps, "t4_ff");

    // 5: reset in the middle of data bit 4, then a fresh frame
    build(8'h12, 0, 1'b0, 1'b1, 1'b1, lv);
    for (int k = 0; k < 5; k++) begin
      bus0.rx = lv[k];
      repeat (CPB) @(negedge clk);
    end
    bus0.rx = lv[5];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("t5_in_reset");
    bus0.rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    build(8'h34, 0, 1'b0, 1'b1, 1'b1, lv);
    send(0, lv);
    exps = {model(lv, 0)};
    expect_frames(0, exps, "t5_34");

    // back-to-back frames with no idle gap
    build(8'h6E, 0, 1'b0, 1'b1, 1'b1, lv);
    build(8'h91, 0, 1'b1, 1'b1, 1'b1, lv2);
    exps = {model(lv, 0), model(lv2, 0)};
    lv = {lv, lv2};
    send(0, lv);
    expect_frames(0, exps, "b2b");

    // random frames on both receivers
    for (int i = 0; i < 16; i++) begin
      w   = i % 2;
      d   = DB'($urandom);
      bp  = ($urandom_range(0, 3) == 0);
      s0  = ($urandom_range(0, 3) != 0);
      s1  = ($urandom_range(0, 3) != 0);
      build(d, w, bp, s0, s1, lv);
      exps = {model(lv, w)};
      gap = $urandom_range(lv[lv.size() - 1] ? 0 : 1, 2);
      for (int k = 0; k < gap; k++) lv.push_back(1'b1);
      send(w, lv);
      repeat ($urandom_range(0, 7)) @(negedge clk);
      expect_frames(w, exps, $sformatf("rand%0d", i));
    end

    // 6: sustained break gives exactly one strobe
    lv = {};
    for (int k = 0; k < 20; k++) lv.push_back(1'b0);
    exps = {model(lv, 0)};
    send(0, lv);
    expect_frames(0, exps, "t6_break");
    build(8'hC3, 0, 1'b0, 1'b1, 1'b1, lv);
    send(0, lv);
    exps = {model(lv, 0)};
    expect_frames(0, exps, "t6_after_break");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
